snitch_icache_refill_arb: RTL and testbench
===========================================

SNITCH_ICACHE_REFILL_ARB -- requirements
Module: snitch_icache_refill_arb

Interface
REQ-001 SHALL have parameter NR_FETCH_PORTS, default 2, number of L0 requesters (1..8).
REQ-002 SHALL have parameter FETCH_AW, default 32, line address width.
REQ-003 SHALL have parameter LINE_WIDTH, default 128, refill line width; refill ID is one-hot, width ID_WIDTH = NR_FETCH_PORTS.
REQ-004 SHALL have port clk_i  in  1  single clock; all state rising-edge.
REQ-005 SHALL have port rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports in_req_addr_i  in  NR_FETCH_PORTS x FETCH_AW; in_req_valid_i  in  NR_FETCH_PORTS; in_req_ready_o  out  NR_FETCH_PORTS (per-port refill request).
REQ-007 SHALL have ports in_rsp_data_o  out  NR_FETCH_PORTS x LINE_WIDTH; in_rsp_error_o, in_rsp_valid_o  out  NR_FETCH_PORTS; in_rsp_ready_i  in  NR_FETCH_PORTS (per-port refill response).
REQ-008 SHALL have ports out_req_addr_o  out  FETCH_AW; out_req_id_o  out  ID_WIDTH; out_req_valid_o  out  1; out_req_ready_i  in  1 (shared L1 lookup request).
REQ-009 SHALL have ports out_rsp_data_i  in  LINE_WIDTH; out_rsp_error_i  in  1; out_rsp_id_i  in  ID_WIDTH; out_rsp_valid_i  in  1; out_rsp_ready_o  out  1 (shared L1 response, id may be multi-hot for merged lines).
REQ-010 SHALL have port stall_o  out  NR_FETCH_PORTS  port i requesting but not granted this cycle (l0_stall event source).

Function
REQ-011 SHALL keep per-port pending[i] register: set on request handshake of port i, cleared on response delivery to port i; each port has at most one outstanding refill.
REQ-012 SHALL consider port i eligible when in_req_valid_i[i] & ~pending[i] (registered pending value).
REQ-013 SHALL arbitrate round-robin: search from priority pointer upward with wrap, first eligible port wins.
REQ-014 SHALL drive out_req_valid_o=1, out_req_addr_o=in_req_addr_i[g], out_req_id_o=one-hot(g) when a grant g exists.
REQ-015 SHALL lock the grant while out_req_valid_o=1 & out_req_ready_i=0: same port, same address, valid held until handshake regardless of other requesters.
REQ-016 SHALL assert in_req_ready_o[g]=out_req_ready_i only for the granted port; others 0.
REQ-017 SHALL, on request handshake, set pointer to (g+1) mod NR_FETCH_PORTS and lock release takes effect next cycle.
REQ-018 SHALL assert stall_o[i] when in_req_valid_i[i]=1 and (in_req_ready_o[i]=0 or pending[i]=1).
REQ-019 SHALL define targeted mask T = out_rsp_id_i & pending; id bits of non-pending ports SHALL be ignored.
REQ-020 SHALL drive in_rsp_valid_o[i] = out_rsp_valid_i & T[i] & ~served[i], with data/error broadcast to all ports.
REQ-021 SHALL keep served mask register: set bit i on handshake at port i while out_rsp_ready_o=0; cleared when out_rsp_ready_o=1.
REQ-022 SHALL assert out_rsp_ready_o when every bit of T is served or handshaking this cycle; T=0 with valid SHALL be accepted immediately (dropped).
REQ-023 SHALL clear pending[i] on the cycle port i's response handshakes; port i becomes eligible the following cycle (no same-cycle re-grant).
REQ-024 SHALL not let request handshake and response delivery of the same port coincide (excluded by pending).
REQ-025 SHALL hold request and response paths independent; simultaneous request handshake on port a and response to port b both take effect.

Reset
REQ-026 SHALL on rst_ni=0 asynchronously clear pending, served, pointer (to 0) and lock.
REQ-027 SHALL during reset drive all valid/ready/stall outputs 0; data/addr/id outputs 0.
REQ-028 SHALL on reset mid-transaction discard outstanding refills; late L1 responses then target no pending port and are dropped per REQ-022.

Verification
REQ-029 SHALL cover: ports 0,1 both valid from reset, out_req_ready_i=1 -> grants 0 then 1, ids 01 then 10.
REQ-030 SHALL cover: port 1 valid, out_req_ready_i=0 for 3 cycles, port 0 raises valid in cycle 2 -> grant stays port 1, addr stable, stall_o[0]=1 until handshake.
REQ-031 SHALL cover: both pending, response id=11, in_rsp_ready_i=01 then 10 -> port 0 served cycle 1, port 1 cycle 2, out_rsp_ready_o=1 only in cycle 2, pending=00 after.
REQ-032 SHALL cover: port 0 pending and valid again -> no grant, stall_o[0]=1; response delivered -> port 0 granted next cycle.
REQ-033 SHALL cover: response id=10 while only port 0 pending -> out_rsp_ready_o=1 same cycle, no in_rsp_valid_o asserted.
REQ-034 SHALL cover: rst_ni low while port 0 pending and out_req_valid_o=1 -> all outputs 0 immediately, pending=0, pointer=0 after release.

Source files
------------

// File: rtl/snitch_icache_refill_arb.sv
// Refill arbiter between the per-core L0 instruction caches and the shared L1 lookup.
// Requests are granted round-robin, one outstanding refill per port; responses are
// fanned out to every pending port whose id bit is set (merged lines).
module snitch_icache_refill_arb #(
  parameter int unsigned NR_FETCH_PORTS = 2,
  parameter int unsigned FETCH_AW       = 32,
  parameter int unsigned LINE_WIDTH     = 128,
  localparam int unsigned ID_WIDTH      = NR_FETCH_PORTS
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  // Per-port refill request
  input  logic [NR_FETCH_PORTS-1:0][FETCH_AW-1:0]  in_req_addr_i,
  input  logic [NR_FETCH_PORTS-1:0]                in_req_valid_i,
  output logic [NR_FETCH_PORTS-1:0]                in_req_ready_o,
  // Per-port refill response
  output logic [NR_FETCH_PORTS-1:0][LINE_WIDTH-1:0] in_rsp_data_o,
  output logic [NR_FETCH_PORTS-1:0]                in_rsp_error_o,
  output logic [NR_FETCH_PORTS-1:0]                in_rsp_valid_o,
  input  logic [NR_FETCH_PORTS-1:0]                in_rsp_ready_i,
  // Shared L1 lookup request
  output logic [FETCH_AW-1:0]                      out_req_addr_o,
  output logic [ID_WIDTH-1:0]                      out_req_id_o,
  output logic                                     out_req_valid_o,
  input  logic                                     out_req_ready_i,
  // Shared L1 response
  input  logic [LINE_WIDTH-1:0]                    out_rsp_data_i,
  input  logic                                     out_rsp_error_i,
  input  logic [ID_WIDTH-1:0]                      out_rsp_id_i,
  input  logic                                     out_rsp_valid_i,
  output logic                                     out_rsp_ready_o,
  // Port requesting but not granted this cycle
  output logic [NR_FETCH_PORTS-1:0]                stall_o
);

  localparam int unsigned IdxW = (NR_FETCH_PORTS > 1) ? $clog2(NR_FETCH_PORTS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NR_FETCH_PORTS - 1);

  logic [NR_FETCH_PORTS-1:0] pending_q, pending_d;
  logic [NR_FETCH_PORTS-1:0] served_q, served_d;
  logic [IdxW-1:0]           ptr_q, ptr_d;
  logic                      lock_q, lock_d;
  logic [IdxW-1:0]           lock_idx_q, lock_idx_d;
  logic [FETCH_AW-1:0]       lock_addr_q, lock_addr_d;

  logic [NR_FETCH_PORTS-1:0] eligible;
  logic                      rr_found;
  logic [IdxW-1:0]           rr_idx;
  int unsigned               rr_cand;
  logic                      grant_valid;
  logic [IdxW-1:0]           grant_idx;
  logic [FETCH_AW-1:0]       grant_addr;
  logic [ID_WIDTH-1:0]       grant_onehot;
  logic                      req_hs;
  logic [NR_FETCH_PORTS-1:0] req_hs_vec;

  logic [NR_FETCH_PORTS-1:0] targeted;
  logic [NR_FETCH_PORTS-1:0] rsp_valid;
  logic [NR_FETCH_PORTS-1:0] rsp_hs;
  logic                      rsp_done;

  assign eligible = in_req_valid_i & ~pending_q;

  // Round-robin search from the priority pointer upward, wrapping at the last port.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_cand  = 0;
    for (int unsigned k = 0; k < NR_FETCH_PORTS; k++) begin
      rr_cand = 32'(ptr_q) + k;
      if (rr_cand >= NR_FETCH_PORTS) rr_cand = rr_cand - NR_FETCH_PORTS;
      if (!rr_found && eligible[rr_cand]) begin
        rr_found = 1'b1;
        rr_idx   = IdxW'(rr_cand);
      end
    end
  end

  // A stalled request keeps its port and address until the L1 accepts it.
  always_comb begin
    grant_valid  = lock_q | rr_found;
    grant_idx    = lock_q ? lock_idx_q : rr_idx;
    grant_addr   = lock_q ? lock_addr_q : in_req_addr_i[rr_idx];
    grant_onehot = '0;
    if (grant_valid) grant_onehot[grant_idx] = 1'b1;
    req_hs     = grant_valid & out_req_ready_i;
    req_hs_vec = req_hs ? grant_onehot : '0;
  end

  // Response fan-out: only pending ports are targeted; already-served ports are masked.
  always_comb begin
    targeted  = out_rsp_id_i & pending_q;
    rsp_valid = {NR_FETCH_PORTS{out_rsp_valid_i}} & targeted & ~served_q;
    rsp_hs    = rsp_valid & in_rsp_ready_i;
    rsp_done  = &(~targeted | served_q | rsp_hs);
  end

  // Next-state for pending, served, pointer and lock.
  always_comb begin
    pending_d   = (pending_q | req_hs_vec) & ~rsp_hs;
    served_d    = rsp_done ? '0 : (served_q | rsp_hs);
    ptr_d       = ptr_q;
    lock_d      = grant_valid & ~out_req_ready_i;
    lock_idx_d  = grant_idx;
    lock_addr_d = grant_addr;
    if (req_hs) ptr_d = (grant_idx == LastIdx) ? '0 : grant_idx + 1'b1;
  end

  // State registers, cleared asynchronously so stale refills are forgotten.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q   <= '0;
      served_q    <= '0;
      ptr_q       <= '0;
      lock_q      <= 1'b0;
      lock_idx_q  <= '0;
      lock_addr_q <= '0;
    end else begin
      pending_q   <= pending_d;
      served_q    <= served_d;
      ptr_q       <= ptr_d;
      lock_q      <= lock_d;
      lock_idx_q  <= lock_idx_d;
      lock_addr_q <= lock_addr_d;
    end
  end

  // Outputs are forced quiet while reset is asserted.
  always_comb begin
    out_req_valid_o = rst_ni & grant_valid;
    out_req_addr_o  = (rst_ni && grant_valid) ? grant_addr : '0;
    out_req_id_o    = rst_ni ? grant_onehot : '0;
    in_req_ready_o  = (rst_ni && out_req_ready_i) ? grant_onehot : '0;
    stall_o         = rst_ni ? (in_req_valid_i & (~in_req_ready_o | pending_q)) : '0;
    in_rsp_valid_o  = rst_ni ? rsp_valid : '0;
    out_rsp_ready_o = rst_ni & rsp_done;
    for (int unsigned i = 0; i < NR_FETCH_PORTS; i++) begin
      in_rsp_data_o[i]  = rst_ni ? out_rsp_data_i : '0;
      in_rsp_error_o[i] = rst_ni & out_rsp_error_i;
    end
  end

endmodule

// File: tb/tb_snitch_icache_refill_arb.sv
// Bench for the refill arbiter: cycle table plus reset and lock sequences,
// with a scoreboard of expected L1 request handshakes.
module tb_snitch_icache_refill_arb;

  localparam logic [31:0] A0 = 32'h0000_1000;
  localparam logic [31:0] A1 = 32'h0000_2000;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic [1:0][31:0]  in_req_addr_i;
  logic [1:0]        in_req_valid_i;
  logic [1:0]        in_req_ready_o;
  logic [1:0][127:0] in_rsp_data_o;
  logic [1:0]        in_rsp_error_o;
  logic [1:0]        in_rsp_valid_o;
  logic [1:0]        in_rsp_ready_i;
  logic [31:0]       out_req_addr_o;
  logic [1:0]        out_req_id_o;
  logic              out_req_valid_o;
  logic              out_req_ready_i;
  logic [127:0]      out_rsp_data_i;
  logic              out_rsp_error_i;
  logic [1:0]        out_rsp_id_i;
  logic              out_rsp_valid_i;
  logic              out_rsp_ready_o;
  logic [1:0]        stall_o;

  snitch_icache_refill_arb #(
    .NR_FETCH_PORTS(2),
    .FETCH_AW      (32),
    .LINE_WIDTH    (128)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .in_req_addr_i  (in_req_addr_i),
    .in_req_valid_i (in_req_valid_i),
    .in_req_ready_o (in_req_ready_o),
    .in_rsp_data_o  (in_rsp_data_o),
    .in_rsp_error_o (in_rsp_error_o),
    .in_rsp_valid_o (in_rsp_valid_o),
    .in_rsp_ready_i (in_rsp_ready_i),
    .out_req_addr_o (out_req_addr_o),
    .out_req_id_o   (out_req_id_o),
    .out_req_valid_o(out_req_valid_o),
    .out_req_ready_i(out_req_ready_i),
    .out_rsp_data_i (out_rsp_data_i),
    .out_rsp_error_i(out_rsp_error_i),
    .out_rsp_id_i   (out_rsp_id_i),
    .out_rsp_valid_i(out_rsp_valid_i),
    .out_rsp_ready_o(out_rsp_ready_o),
    .stall_o        (stall_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [1:0] valid;
    logic       ordy;
    logic       rvalid;
    logic [1:0] rid;
    logic [1:0] rrdy;
    logic       e_oval;
    logic [1:0] e_id;
    logic [1:0] e_irdy;
    logic [1:0] e_stall;
    logic [1:0] e_rval;
    logic       e_ordy;
  } vec_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  id;
  } req_t;

  int   n_checks = 0;
  int   n_errors = 0;
  req_t exp_q[$];
  vec_t tbl[9];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] addr_of(input logic [1:0] id);
    return (id == 2'b01) ? A0 : (id == 2'b10) ? A1 : 32'h0;
  endfunction

  // Scoreboard: every L1 request handshake must match the next expected one.
  always @(negedge clk_i) begin
    if (rst_ni && out_req_valid_o && out_req_ready_i) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_unexpected: got id %0b addr %0h required no handshake",
                 out_req_id_o, out_req_addr_o);
      end else begin
        req_t e;
        e = exp_q.pop_front();
        chk("sb_addr", 128'(out_req_addr_o), 128'(e.addr));
        chk("sb_id", 128'(out_req_id_o), 128'(e.id));
      end
    end
  end

  task automatic drive(input vec_t v, input int tag);
    in_req_valid_i  = v.valid;
    out_req_ready_i = v.ordy;
    out_rsp_valid_i = v.rvalid;
    out_rsp_id_i    = v.rid;
    in_rsp_ready_i  = v.rrdy;
    out_rsp_data_i  = {4{32'hC0DE_0000 | 32'(tag)}};
    out_rsp_error_i = tag[0];
  endtask

  task automatic run_vec(input vec_t v, input int tag);
    @(posedge clk_i);
    #1;
    drive(v, tag);
    if (v.e_oval && v.ordy) exp_q.push_back('{addr: addr_of(v.e_id), id: v.e_id});
    @(negedge clk_i);
    chk($sformatf("v%0d_out_valid", tag), 128'(out_req_valid_o), 128'(v.e_oval));
    chk($sformatf("v%0d_out_id", tag), 128'(out_req_id_o), 128'(v.e_id));
    chk($sformatf("v%0d_out_addr", tag), 128'(out_req_addr_o), 128'(addr_of(v.e_id)));
    chk($sformatf("v%0d_in_ready", tag), 128'(in_req_ready_o), 128'(v.e_irdy));
    chk($sformatf("v%0d_stall", tag), 128'(stall_o), 128'(v.e_stall));
    chk($sformatf("v%0d_rsp_valid", tag), 128'(in_rsp_valid_o), 128'(v.e_rval));
    chk($sformatf("v%0d_rsp_ready", tag), 128'(out_rsp_ready_o), 128'(v.e_ordy));
    if (v.rvalid) begin
      chk($sformatf("v%0d_data1", tag), in_rsp_data_o[1], {4{32'hC0DE_0000 | 32'(tag)}});
      chk($sformatf("v%0d_err0", tag), 128'(in_rsp_error_o[0]), 128'(tag[0]));
    end
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_out_valid"}, 128'(out_req_valid_o), 128'(0));
    chk({tag, "_out_id"}, 128'(out_req_id_o), 128'(0));
    chk({tag, "_out_addr"}, 128'(out_req_addr_o), 128'(0));
    chk({tag, "_in_ready"}, 128'(in_req_ready_o), 128'(0));
    chk({tag, "_stall"}, 128'(stall_o), 128'(0));
    chk({tag, "_rsp_valid"}, 128'(in_rsp_valid_o), 128'(0));
    chk({tag, "_rsp_ready"}, 128'(out_rsp_ready_o), 128'(0));
    chk({tag, "_data0"}, in_rsp_data_o[0], 128'(0));
  endtask

  // Reset with busy inputs applied, then quiet the inputs before release.
  task automatic do_reset(input string tag);
    rst_ni          = 1'b0;
    in_req_valid_i  = 2'b11;
    out_req_ready_i = 1'b1;
    out_rsp_valid_i = 1'b1;
    out_rsp_id_i    = 2'b11;
    in_rsp_ready_i  = 2'b11;
    out_rsp_data_i  = {4{32'hDEAD_BEEF}};
    #1;
    check_quiet(tag);
    @(posedge clk_i);
    @(posedge clk_i);
    in_req_valid_i  = 2'b00;
    out_req_ready_i = 1'b0;
    out_rsp_valid_i = 1'b0;
    out_rsp_id_i    = 2'b00;
    in_rsp_ready_i  = 2'b00;
    #3;
    rst_ni = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    in_req_addr_i[0] = A0;
    in_req_addr_i[1] = A1;
    //          valid ordy rv rid  rrdy | oval id  irdy stall rval ordy
    tbl[0] = {2'b11, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 2'b01, 2'b01, 2'b10, 2'b00, 1'b1};
    tbl[1] = {2'b11, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 2'b10, 2'b10, 2'b01, 2'b00, 1'b1};
    tbl[2] = {2'b01, 1'b1, 1'b1, 2'b11, 2'b01, 1'b0, 2'b00, 2'b00, 2'b01, 2'b11, 1'b0};
    tbl[3] = {2'b01, 1'b1, 1'b1, 2'b11, 2'b10, 1'b1, 2'b01, 2'b01, 2'b00, 2'b10, 1'b1};
    tbl[4] = {2'b00, 1'b1, 1'b1, 2'b10, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1};
    tbl[5] = {2'b00, 1'b1, 1'b1, 2'b01, 2'b01, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 1'b1};
    tbl[6] = {2'b11, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 2'b10, 2'b10, 2'b01, 2'b00, 1'b1};
    tbl[7] = {2'b01, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 2'b01, 2'b00, 2'b01, 2'b00, 1'b1};
    tbl[8] = {2'b01, 1'b1, 1'b1, 2'b10, 2'b10, 1'b1, 2'b01, 2'b01, 2'b00, 2'b10, 1'b1};

    do_reset("rst0");
    for (int i = 0; i < 9; i++) run_vec(tbl[i], i);

    // Port 0 pending, port 1 request held off by the L1, then reset mid-transaction.
    run_vec({2'b10, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 2'b10, 2'b00, 2'b10, 2'b00, 1'b1}, 20);
    @(posedge clk_i);
    out_rsp_valid_i = 1'b1;
    out_rsp_id_i    = 2'b11;
    in_rsp_ready_i  = 2'b11;
    #2;
    rst_ni = 1'b0;
    #1;
    check_quiet("midrst");
    @(posedge clk_i);
    @(posedge clk_i);
    #3;
    // Late response for the discarded refill plus fresh requests from both ports.
    in_req_valid_i  = 2'b11;
    out_req_ready_i = 1'b0;
    out_rsp_valid_i = 1'b1;
    out_rsp_id_i    = 2'b01;
    in_rsp_ready_i  = 2'b00;
    rst_ni          = 1'b1;
    @(negedge clk_i);
    chk("postrst_out_valid", 128'(out_req_valid_o), 128'(1));
    chk("postrst_out_id", 128'(out_req_id_o), 128'(2'b01));
    chk("postrst_out_addr", 128'(out_req_addr_o), 128'(A0));
    chk("postrst_stall", 128'(stall_o), 128'(2'b11));
    chk("postrst_rsp_valid", 128'(in_rsp_valid_o), 128'(2'b00));
    chk("postrst_rsp_ready", 128'(out_rsp_ready_o), 128'(1));

    // Grant to port 1 stays locked while the L1 stalls, even once port 0 requests.
    do_reset("rst1");
    run_vec({2'b10, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 2'b10, 2'b00, 2'b10, 2'b00, 1'b1}, 30);
    run_vec({2'b11, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 2'b10, 2'b00, 2'b11, 2'b00, 1'b1}, 31);
    run_vec({2'b11, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 2'b10, 2'b00, 2'b11, 2'b00, 1'b1}, 32);
    run_vec({2'b11, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 2'b10, 2'b10, 2'b01, 2'b00, 1'b1}, 33);
    run_vec({2'b01, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 2'b01, 2'b01, 2'b00, 2'b00, 1'b1}, 34);
    run_vec({2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1}, 35);

    chk("sb_drain", 128'(exp_q.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
